post_eval: RTL and testbench
============================

# post_eval

Postfix expression evaluator: consumes the same 6-bit token stream (IN / IN_VALID / OP_VALID) that the infix-to-postfix converter emits and computes the arithmetic result of each expression with a token stack. It sits downstream of the converter in the expression datapath. It returns one 16-bit result per frame, with an error flag for malformed expressions.

## Interface
- DEPTH, 16: stack entries; also the maximum operands live at once.
- DW, 16: result and stack word width.
- CLK  input  1  clock; everything is sampled on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- IN  input  6  token: operand value (unsigned 0..63) or ASCII operator code.
- IN_VALID  input  1  token on IN is valid this cycle; a frame is a run of consecutive IN_VALID=1 cycles.
- OP_VALID  input  1  qualifies IN as an operator; ignored when IN_VALID=0.
- OUT  output  DW  result of the last completed frame.
- OUT_VALID  output  1  one-cycle pulse marking OUT/ERR valid.
- ERR  output  1  frame was malformed; qualified by OUT_VALID.

## Operation
- Operators: '+' 6'h2B, '-' 6'h2D, '*' 6'h2A. Any other code with OP_VALID=1 is illegal.
- Operand token (IN_VALID=1, OP_VALID=0):
  - pushes zero-extended IN.
  - If sp==DEPTH, the token is dropped and the frame error is set.
- Operator token:
  - pops b (top) and a (next), then pushes a op b.
  - Arithmetic is DW-bit two's complement with wrap.
  - '-' is a-b. '*' keeps the low DW bits of the product.
  - If sp<2 or the code is illegal, the stack is unchanged and the frame error is set.
- States:
  - IDLE (reset)
    - IN_VALID=1: go to LOAD, sp cleared, first token processed, error cleared.
  - LOAD
    - IN_VALID=1: process the token.
    - IN_VALID=0: go to DONE.
  - DONE (OUT_VALID=1 for exactly this cycle)
    - IN_VALID=1: begin a new frame exactly as from IDLE.
    - IN_VALID=0: go to IDLE.
- Result at the LOAD->DONE edge:
  - If error is clear and sp==1: OUT=stack top, ERR=0.
  - Otherwise: OUT=0, ERR=1. This covers sp==0 and sp>1.
- OUT holds its value until the next DONE. ERR is held the same way.

## Timing
- Throughput: one token per cycle, no back-pressure.
- Latency: OUT_VALID rises on the first rising edge at which IN_VALID is sampled 0 after a frame, and is high for one cycle.
- A new frame may start in the DONE cycle; frames are separated by a minimum gap of one IN_VALID=0 cycle.
- Reset values: OUT=0, OUT_VALID=0, ERR=0, sp=0, state IDLE.
- Reset asserted mid-frame:
  - the frame is discarded and no OUT_VALID pulse is produced for it;
  - tokens sampled in reset cycles are ignored.
- Reset has priority over all other events in the same cycle.
- Push-when-full and pop-when-short never corrupt stored entries. sp stays in 0..DEPTH.

## Structure
- Shared package post_pkg:
  - operator codes TOK_ADD/TOK_SUB/TOK_MUL;
  - state enum {IDLE, LOAD, DONE};
  - DW and DEPTH defaults.
  - The converter uses the same package for its token codes.
- Sub-module eval_stack: DEPTH x DW register LIFO with push, pop2_push (replace the top two entries with one) and clear.
  - Outputs: top, next, sp, full, lt2.
- post_eval holds the FSM, the ALU (+, -, *) and the error/result registers.

## Test plan
- Tokens 3,4,'+',2,'*' (operators flagged), then IN_VALID=0 -> OUT=14, ERR=0, OUT_VALID high for one cycle on the edge after the last token.
- 5,9,'-' -> OUT=16'hFFFC, ERR=0.
- 63,63,'*',63,'*',63,'*' -> OUT=16'h5F01 (63^4 mod 2^16), ERR=0.
- Malformed frames, each -> OUT=0, ERR=1:
  - '+' alone;
  - 1,2 (sp==2 at end);
  - 17 consecutive operands;
  - operator code 6'h2F.
- Reset:
  - RESET pulsed after 1,2 of a frame -> no OUT_VALID for that frame.
  - Next frame 1,2,'+' -> OUT=3.
- Back-to-back frames 7 | gap of 1 | 2,3,'*' -> OUT=7 then OUT=6, two separate OUT_VALID pulses, stack cleared between frames.

Source files
------------

// File: rtl/post_pkg.sv
// Shared definitions for the expression datapath: token codes, FSM states and
// default datapath sizes. The infix-to-postfix converter uses the same codes.
package post_pkg;

  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned DEPTH_DEF = 16;

  localparam logic [5:0] TOK_ADD = 6'h2B;
  localparam logic [5:0] TOK_SUB = 6'h2D;
  localparam logic [5:0] TOK_MUL = 6'h2A;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

  // True for the operator codes the ALU understands.
  function automatic logic is_legal_op(input logic [5:0] code);
    return (code == TOK_ADD) || (code == TOK_SUB) || (code == TOK_MUL);
  endfunction

endpackage

// File: rtl/eval_stack.sv
// Register-based LIFO for the postfix evaluator. Supports push, pop2_push
// (replace the top two entries with one) and clear. Clear combines with a push
// in the same cycle so a new frame can load its first operand immediately.
module eval_stack #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop2_push_i,
  input  logic [DW-1:0]              din_i,
  output logic [DW-1:0]              top_o,
  output logic [DW-1:0]              next_o,
  output logic [$clog2(DEPTH+1)-1:0] sp_o,
  output logic                       full_o,
  output logic                       lt2_o
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]  mem_q [DEPTH];
  logic [DW-1:0]  mem_d [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [SPW-1:0] base;
  logic [IW-1:0]  top_idx, next_idx, wr_idx, rep_idx;

  // Read side: top and next entries, zero when not present.
  always_comb begin
    top_idx  = IW'(sp_q - SPW'(1));
    next_idx = IW'(sp_q - SPW'(2));
    top_o    = (sp_q >= SPW'(1)) ? mem_q[top_idx] : '0;
    next_o   = (sp_q >= SPW'(2)) ? mem_q[next_idx] : '0;
    sp_o     = sp_q;
    full_o   = (sp_q == SPW'(DEPTH));
    lt2_o    = (sp_q < SPW'(2));
  end

  // Write side: out-of-range requests are ignored so stored entries stay intact.
  always_comb begin
    mem_d   = mem_q;
    base    = clear_i ? '0 : sp_q;
    sp_d    = base;
    wr_idx  = IW'(base);
    rep_idx = IW'(base - SPW'(2));
    if (rst_i) begin
      sp_d = '0;
    end else if (push_i) begin
      if (base != SPW'(DEPTH)) begin
        mem_d[wr_idx] = din_i;
        sp_d          = base + SPW'(1);
      end
    end else if (pop2_push_i) begin
      if (base >= SPW'(2)) begin
        mem_d[rep_idx] = din_i;
        sp_d           = base - SPW'(1);
      end
    end
  end

  // Stack pointer with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Storage needs no reset; entries above sp are never read.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/post_eval.sv
// Postfix expression evaluator. Consumes one 6-bit token per cycle, evaluates
// with a LIFO and reports one result per frame with an error flag.
module post_eval
  import post_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [5:0]    IN,
  input  logic          IN_VALID,
  input  logic          OP_VALID,
  output logic [DW-1:0] OUT,
  output logic          OUT_VALID,
  output logic          ERR
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);

  state_e         state_q, state_d;
  logic           frame_err_q, frame_err_d;
  logic [DW-1:0]  out_q, out_d;
  logic           err_q, err_d;
  logic           out_valid_q, out_valid_d;

  logic           stk_clear, stk_push, stk_pop2;
  logic [DW-1:0]  stk_din, stk_top, stk_next;
  logic [SPW-1:0] stk_sp;
  logic           stk_full, stk_lt2;
  logic           start, eff_full, eff_lt2, tok_err;
  logic [DW-1:0]  alu_res;

  eval_stack #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_stack (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .clear_i     (stk_clear),
    .push_i      (stk_push),
    .pop2_push_i (stk_pop2),
    .din_i       (stk_din),
    .top_o       (stk_top),
    .next_o      (stk_next),
    .sp_o        (stk_sp),
    .full_o      (stk_full),
    .lt2_o       (stk_lt2)
  );

  // ALU: a = next, b = top; results wrap to DW bits.
  always_comb begin
    alu_res = '0;
    case (IN)
      TOK_ADD: alu_res = stk_next + stk_top;
      TOK_SUB: alu_res = stk_next - stk_top;
      TOK_MUL: alu_res = stk_next * stk_top;
      default: alu_res = '0;
    endcase
  end

  // Token decode, stack control and FSM next state.
  always_comb begin
    state_d     = state_q;
    frame_err_d = frame_err_q;
    out_d       = out_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    stk_clear   = 1'b0;
    stk_push    = 1'b0;
    stk_pop2    = 1'b0;
    tok_err     = 1'b0;
    stk_din     = OP_VALID ? alu_res : {{(DW - 6){1'b0}}, IN};

    // A token arriving outside LOAD opens a new frame against an empty stack.
    start    = IN_VALID && (state_q != LOAD);
    eff_full = start ? 1'b0 : stk_full;
    eff_lt2  = start ? 1'b1 : stk_lt2;

    if (IN_VALID) begin
      if (OP_VALID) begin
        if (!is_legal_op(IN) || eff_lt2) tok_err = 1'b1;
        else                              stk_pop2 = 1'b1;
      end else begin
        if (eff_full) tok_err = 1'b1;
        else          stk_push = 1'b1;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (IN_VALID) begin
          state_d     = LOAD;
          stk_clear   = 1'b1;
          frame_err_d = tok_err;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (IN_VALID) begin
          frame_err_d = frame_err_q | tok_err;
        end else begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          if (!frame_err_q && (stk_sp == SPW'(1))) begin
            out_d = stk_top;
            err_d = 1'b0;
          end else begin
            out_d = '0;
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered outputs; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      frame_err_q <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_err_q <= frame_err_d;
      out_q       <= out_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign OUT       = out_q;
  assign ERR       = err_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_post_eval.sv
// Self-checking bench for post_eval: frames are driven on the falling edge,
// expected results are queued when a frame is sent and popped on OUT_VALID.
module tb_post_eval;
  import post_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [5:0]  IN;
  logic        IN_VALID;
  logic        OP_VALID;
  logic [15:0] OUT;
  logic        OUT_VALID;
  logic        ERR;

  typedef struct packed {
    logic [15:0] out;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  post_eval #(
    .DEPTH (16),
    .DW    (16)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN        (IN),
    .IN_VALID  (IN_VALID),
    .OP_VALID  (OP_VALID),
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: every OUT_VALID pulse must match the oldest queued frame.
  always @(negedge CLK) begin
    if (!RESET && OUT_VALID) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_pulse: OUT=%h ERR=%b, no frame pending", OUT, ERR);
      end else begin
        e = sb.pop_front();
        if (OUT !== e.out || ERR !== e.err)
          $display("FAIL result: OUT=%h ERR=%b, required OUT=%h ERR=%b", OUT, ERR, e.out, e.err);
        else passes++;
      end
    end
  end

  task automatic tok(input logic op, input logic [5:0] v);
    IN_VALID = 1'b1;
    OP_VALID = op;
    IN       = v;
    @(negedge CLK);
  endtask

  // Drop IN_VALID and check the pulse shows up right after that edge.
  task automatic end_frame(input string name);
    IN_VALID = 1'b0;
    OP_VALID = 1'b0;
    IN       = '0;
    @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b1) $display("FAIL %s_latency: OUT_VALID=%b, required 1", name, OUT_VALID);
    else passes++;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 8) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (sb.size() != 0) $display("FAIL %s_drain: %0d results pending, required 0", name, sb.size());
    else passes++;
  endtask

  task automatic test_reset();
    RESET = 1'b1; IN_VALID = 1'b0; OP_VALID = 1'b0; IN = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (OUT !== 16'h0 || ERR !== 1'b0 || OUT_VALID !== 1'b0)
      $display("FAIL reset_state: OUT=%h ERR=%b OUT_VALID=%b, required 0 0 0", OUT, ERR, OUT_VALID);
    else passes++;
  endtask

  task automatic test_arith();
    sb.push_back('{out: 16'd14, err: 1'b0});
    tok(0, 3); tok(0, 4); tok(1, TOK_ADD); tok(0, 2); tok(1, TOK_MUL);
    end_frame("add_mul");
    @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b0) $display("FAIL pulse_width: OUT_VALID=%b, required 0", OUT_VALID);
    else passes++;
    drain("add_mul");

    sb.push_back('{out: 16'hFFFC, err: 1'b0});
    tok(0, 5); tok(0, 9); tok(1, TOK_SUB);
    end_frame("sub_wrap");
    @(negedge CLK);
    drain("sub_wrap");

    sb.push_back('{out: 16'h5F01, err: 1'b0});
    tok(0, 63); tok(0, 63); tok(1, TOK_MUL);
    tok(0, 63); tok(1, TOK_MUL);
    tok(0, 63); tok(1, TOK_MUL);
    end_frame("mul_wrap");
    @(negedge CLK);
    drain("mul_wrap");

    // A full but legal stack: 1..16 summed.
    sb.push_back('{out: 16'd136, err: 1'b0});
    for (int i = 1; i <= 16; i++) tok(0, 6'(i));
    for (int i = 0; i < 15; i++) tok(1, TOK_ADD);
    end_frame("full_sum");
    @(negedge CLK);
    drain("full_sum");

    // Result must hold after the pulse.
    repeat (3) @(negedge CLK);
    checks++;
    if (OUT !== 16'd136 || ERR !== 1'b0) $display("FAIL hold: OUT=%h ERR=%b, required 0088 0", OUT, ERR);
    else passes++;
  endtask

  task automatic test_errors();
    sb.push_back('{out: 16'h0, err: 1'b1});
    tok(1, TOK_ADD);
    end_frame("op_alone");
    @(negedge CLK);

    sb.push_back('{out: 16'h0, err: 1'b1});
    tok(0, 1); tok(0, 2);
    end_frame("two_left");
    @(negedge CLK);

    sb.push_back('{out: 16'h0, err: 1'b1});
    for (int i = 0; i < 17; i++) tok(0, 6'(i + 1));
    end_frame("overflow");
    @(negedge CLK);

    // Illegal code sets a sticky error even though the frame ends with sp==1.
    sb.push_back('{out: 16'h0, err: 1'b1});
    tok(0, 1); tok(0, 2); tok(1, 6'h2F); tok(1, TOK_ADD);
    end_frame("bad_op");
    @(negedge CLK);
    drain("errors");

    // A clean frame after errors clears ERR.
    sb.push_back('{out: 16'd10, err: 1'b0});
    tok(0, 2); tok(0, 5); tok(1, TOK_MUL);
    end_frame("recover");
    @(negedge CLK);
    drain("recover");
  endtask

  task automatic test_mid_reset();
    tok(0, 1); tok(0, 2);
    RESET = 1'b1; IN_VALID = 1'b1; OP_VALID = 1'b0; IN = 6'd5;
    @(negedge CLK);
    RESET = 1'b0; IN_VALID = 1'b0; IN = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (OUT_VALID !== 1'b0) $display("FAIL mid_reset_pulse: OUT_VALID=%b, required 0", OUT_VALID);
      else passes++;
    end
    checks++;
    if (OUT !== 16'h0 || ERR !== 1'b0)
      $display("FAIL mid_reset_state: OUT=%h ERR=%b, required 0 0", OUT, ERR);
    else passes++;

    sb.push_back('{out: 16'd3, err: 1'b0});
    tok(0, 1); tok(0, 2); tok(1, TOK_ADD);
    end_frame("after_reset");
    @(negedge CLK);
    drain("after_reset");
  endtask

  task automatic test_back_to_back();
    sb.push_back('{out: 16'd7, err: 1'b0});
    sb.push_back('{out: 16'd6, err: 1'b0});
    tok(0, 7);
    end_frame("b2b_first");
    tok(0, 2); tok(0, 3); tok(1, TOK_MUL);
    end_frame("b2b_second");
    @(negedge CLK);
    drain("b2b");
  endtask

  initial begin
    test_reset();
    test_arith();
    test_errors();
    test_mid_reset();
    test_back_to_back();
    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

endmodule
